// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD bypassed combinational reads, two write
// ports, per-entry scoreboard busy bits and a one-entry-per-cycle clear engine after reset.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     init_done,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        waddr0,
    input  logic [DATA_W-1:0]        wdata0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        waddr1,
    input  logic [DATA_W-1:0]        wdata1,
    input  logic [NUM_RD*ADDR_W-1:0] raddr,
    output logic [NUM_RD*DATA_W-1:0] rdata,
    input  logic                     sb_set,
    input  logic [ADDR_W-1:0]        sb_set_addr,
    output logic [NUM_RD-1:0]        sb_busy
);

    typedef enum logic {INIT, RUN} state_t;

    // Counter is one bit wider than the address so a power-of-two DEPTH cannot wrap.
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

    state_t              state_reg, state_next;
    logic [ADDR_W:0]     clr_cnt_reg, clr_cnt_next;
    logic                init_done_reg, init_done_next;
    logic [DATA_W-1:0]   entry_reg [DEPTH];
    logic [DEPTH-1:0]    busy_reg;

    // An address names a real, writable entry: in range and not the hardwired zero.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= INIT;
            clr_cnt_reg   <= '0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            clr_cnt_reg   <= clr_cnt_next;
            init_done_reg <= init_done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        clr_cnt_next   = clr_cnt_reg;
        init_done_next = init_done_reg;
        case (state_reg)
            INIT: begin
                clr_cnt_next = clr_cnt_reg + 1'b1;
                if (clr_cnt_reg == LAST_IDX) begin
                    state_next     = RUN;
                    init_done_next = 1'b1;
                end
            end
            RUN: ;
            default: state_next = INIT;
        endcase
    end

    assign init_done = init_done_reg;

    // Port 1 is applied after port 0 so it wins a same-address conflict, and the
    // scoreboard set is applied last so a new producer supersedes a writeback.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_reg == INIT) begin
                entry_reg[clr_cnt_reg[ADDR_W-1:0]] <= '0;
                busy_reg[clr_cnt_reg[ADDR_W-1:0]]  <= 1'b0;
            end else begin
                if (we0 && addr_ok(waddr0)) begin
                    entry_reg[waddr0] <= wdata0;
                    busy_reg[waddr0]  <= 1'b0;
                end
                if (we1 && addr_ok(waddr1)) begin
                    entry_reg[waddr1] <= wdata1;
                    busy_reg[waddr1]  <= 1'b0;
                end
                if (sb_set && addr_ok(sb_set_addr)) begin
                    busy_reg[sb_set_addr] <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] rd_val;
            logic              bsy;

            assign ra = raddr[gi*ADDR_W +: ADDR_W];

            // A same-cycle writeback is forwarded and reports not-busy.
            always_comb begin
                rd_val = '0;
                bsy    = 1'b0;
                if (state_reg == RUN && addr_ok(ra)) begin
                    if (we1 && waddr1 == ra) begin
                        rd_val = wdata1;
                    end else if (we0 && waddr0 == ra) begin
                        rd_val = wdata0;
                    end else begin
                        rd_val = entry_reg[ra];
                        bsy    = busy_reg[ra];
                    end
                end
            end

            assign rdata[gi*DATA_W +: DATA_W] = rd_val;
            assign sb_busy[gi]                = bsy;
        end
    endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: default instance (DEPTH=32) and an odd-depth
// instance (DEPTH=20) exercised for mid-run reset and out-of-range addresses.
module tb_regfile_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // instance A: default parameters
    logic        rst, init_done;
    logic        we0, we1, sb_set;
    logic [4:0]  waddr0, waddr1, sb_set_addr;
    logic [31:0] wdata0, wdata1;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  sb_busy;

    // instance B: DEPTH=20
    logic        rst_b, init_done_b;
    logic        we0_b, we1_b, sb_set_b;
    logic [4:0]  waddr0_b, waddr1_b, sb_set_addr_b;
    logic [31:0] wdata0_b, wdata1_b;
    logic [9:0]  raddr_b;
    logic [63:0] rdata_b;
    logic [1:0]  sb_busy_b;

    int n_cmp = 0;
    int n_err = 0;

    regfile_mp dut_a (
        .clk(clk), .rst(rst), .init_done(init_done),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .raddr(raddr), .rdata(rdata),
        .sb_set(sb_set), .sb_set_addr(sb_set_addr), .sb_busy(sb_busy)
    );

    regfile_mp #(.DEPTH(20)) dut_b (
        .clk(clk), .rst(rst_b), .init_done(init_done_b),
        .we0(we0_b), .waddr0(waddr0_b), .wdata0(wdata0_b),
        .we1(we1_b), .waddr1(waddr1_b), .wdata1(wdata1_b),
        .raddr(raddr_b), .rdata(rdata_b),
        .sb_set(sb_set_b), .sb_set_addr(sb_set_addr_b), .sb_busy(sb_busy_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a();
        we0 = 0; we1 = 0; sb_set = 0;
        waddr0 = 0; waddr1 = 0; sb_set_addr = 0;
        wdata0 = 0; wdata1 = 0;
    endtask

    task automatic idle_b();
        we0_b = 0; we1_b = 0; sb_set_b = 0;
        waddr0_b = 0; waddr1_b = 0; sb_set_addr_b = 0;
        wdata0_b = 0; wdata1_b = 0;
    endtask

    initial begin
        idle_a(); idle_b();
        rst = 1; rst_b = 1;
        raddr = 0; raddr_b = 0;
        tick();
        rst = 0;

        // T1: INIT lasts 32 cycles; writes and sb_set during INIT are ignored
        raddr = {5'd9, 5'd5};
        for (int k = 0; k < 32; k++) begin
            if (k == 10) begin we0 = 1; waddr0 = 5; wdata0 = 32'hDEAD; end
            if (k == 20) begin sb_set = 1; sb_set_addr = 9; end
            #1;
            check($sformatf("t1_init_done_low_%0d", k), {31'd0, init_done}, 32'd0);
            if (k == 0 || k == 10 || k == 31)
                check($sformatf("t1_rdata0_init_%0d", k), rdata[31:0], 32'd0);
            tick();
            idle_a();
        end
        check("t1_init_done_high", {31'd0, init_done}, 32'd1);
        #1;
        check("t1_entry5_after_init", rdata[31:0], 32'd0);
        check("t1_busy9_after_init", {31'd0, sb_busy[1]}, 32'd0);

        // T2: write with same-cycle bypass, then stored value
        we0 = 1; waddr0 = 3; wdata0 = 32'h1234_5678; raddr = {5'd0, 5'd3};
        #1;
        check("t2_bypass", rdata[31:0], 32'h1234_5678);
        tick(); idle_a(); #1;
        check("t2_stored", rdata[31:0], 32'h1234_5678);

        // T3: both ports to the same address, port 1 wins
        we0 = 1; waddr0 = 7; wdata0 = 32'hAAAA_AAAA;
        we1 = 1; waddr1 = 7; wdata1 = 32'h5555_5555;
        raddr = {5'd7, 5'd7};
        #1;
        check("t3_bypass_p0", rdata[31:0], 32'h5555_5555);
        check("t3_bypass_p1", rdata[63:32], 32'h5555_5555);
        tick(); idle_a(); #1;
        check("t3_stored", rdata[63:32], 32'h5555_5555);

        // T4: hardwired zero entry
        we1 = 1; waddr1 = 0; wdata1 = 32'hFFFF_FFFF;
        sb_set = 1; sb_set_addr = 0; raddr = {5'd3, 5'd0};
        #1;
        check("t4_zero_same_cycle", rdata[31:0], 32'd0);
        check("t4_zero_busy_same", {31'd0, sb_busy[0]}, 32'd0);
        tick(); idle_a(); #1;
        check("t4_zero_after", rdata[31:0], 32'd0);
        check("t4_zero_busy_after", {31'd0, sb_busy[0]}, 32'd0);
        check("t4_port1_independent", rdata[63:32], 32'h1234_5678);

        // T5: scoreboard set / writeback clear / set-wins
        sb_set = 1; sb_set_addr = 9; raddr = {5'd9, 5'd9};
        #1;
        check("t5_busy_before_edge", {31'd0, sb_busy[0]}, 32'd0);
        tick(); idle_a(); #1;
        check("t5_busy_set_p0", {31'd0, sb_busy[0]}, 32'd1);
        check("t5_busy_set_p1", {31'd0, sb_busy[1]}, 32'd1);
        we1 = 1; waddr1 = 9; wdata1 = 32'h0000_0099;
        #1;
        check("t5_busy_bypass", {31'd0, sb_busy[0]}, 32'd0);
        check("t5_data_bypass", rdata[31:0], 32'h0000_0099);
        tick(); idle_a(); #1;
        check("t5_busy_cleared", {31'd0, sb_busy[0]}, 32'd0);
        check("t5_data_stored", rdata[31:0], 32'h0000_0099);
        sb_set = 1; sb_set_addr = 9; we0 = 1; waddr0 = 9; wdata0 = 32'h0000_0077;
        #1;
        check("t5_set_clr_same_cycle", {31'd0, sb_busy[0]}, 32'd0);
        tick(); idle_a(); #1;
        check("t5_set_wins", {31'd0, sb_busy[0]}, 32'd1);
        check("t5_data_77", rdata[31:0], 32'h0000_0077);

        // T6: odd depth, out-of-range address, mid-run reset
        rst_b = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            check($sformatf("t6_init_done_low_%0d", k), {31'd0, init_done_b}, 32'd0);
            tick();
        end
        check("t6_init_done_high", {31'd0, init_done_b}, 32'd1);
        we0_b = 1; waddr0_b = 3; wdata0_b = 32'h0000_0033;
        we1_b = 1; waddr1_b = 19; wdata1_b = 32'h0000_1919;
        tick(); idle_b();
        we0_b = 1; waddr0_b = 25; wdata0_b = 32'h0000_0BAD;
        raddr_b = {5'd19, 5'd25};
        #1;
        check("t6_oob_bypass", rdata_b[31:0], 32'd0);
        check("t6_entry19", rdata_b[63:32], 32'h0000_1919);
        tick(); idle_b(); #1;
        check("t6_oob_after", rdata_b[31:0], 32'd0);
        raddr_b = {5'd19, 5'd3};
        #1;
        check("t6_entry3", rdata_b[31:0], 32'h0000_0033);
        check("t6_entry19_kept", rdata_b[63:32], 32'h0000_1919);
        rst_b = 1;
        tick();
        rst_b = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            check($sformatf("t6_rerun_low_%0d", k), {31'd0, init_done_b}, 32'd0);
            tick();
        end
        check("t6_rerun_high", {31'd0, init_done_b}, 32'd1);
        #1;
        check("t6_entry3_cleared", rdata_b[31:0], 32'd0);
        check("t6_entry19_cleared", rdata_b[63:32], 32'd0);
        raddr_b = {5'd0, 5'd25};
        #1;
        check("t6_oob_final", rdata_b[31:0], 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
